uart_rx_frontend: RTL and testbench

- Asynchronous serial receiver for the board UART pin (uart_rxd) inside fpga_top.
- Sits upstream of the UART bus peripheral. Deserialises 8N1 frames, or 8E1 with the parity option.
- Presents each byte through a one-entry holding register with a valid/ack handshake.
- Reports sticky overrun, framing and parity errors.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_frontend.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_pkg;

   typedef enum logic [2:0] {
      StArm,
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned SAMPLE_MID = 7;
   localparam int unsigned DATA_BITS  = 8;

   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud);
      return clk_freq / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1 and pulses tick_o at DIV-1.
module uart_baud_tick #(
   parameter int unsigned DIV = 4
) (
   input  logic clk_in,
   input  logic sys_rstn,
   input  logic restart_i,
   output logic tick_o
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CntLast = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart_i || (cnt_q == CntLast)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver with one-entry holding register and sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx_frontend
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 25_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV        = calc_div(CLK_FREQ, BAUD)
) (
   input  logic       clk_in,
   input  logic       sys_rstn,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   input  logic       err_clr,
   output logic       rx_overrun,
   output logic       rx_frame_err,
   output logic       rx_parity_err
);

   localparam logic [3:0] PhLast = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] PhS0   = 4'(SAMPLE_MID);
   localparam logic [3:0] PhS1   = 4'(SAMPLE_MID + 1);
   localparam logic [3:0] PhDec  = 4'(SAMPLE_MID + 2);
   localparam logic [2:0] BitLast = 3'(DATA_BITS - 1);

   logic [1:0] sync_q;
   state_e     state_q;
   logic [3:0] ph_q;
   logic [2:0] bit_q;
   logic [7:0] shift_q;
   logic       s0_q, s1_q;
   logic       commit_q;
   logic [7:0] data_q;
   logic       valid_q, ovr_q, ferr_q;

   logic rxs, tick, restart, maj;

   assign rxs     = sync_q[1];
   assign restart = (state_q == StIdle) && !rxs;
   assign maj     = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

   uart_baud_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk_in    (clk_in),
      .sys_rstn  (sys_rstn),
      .restart_i (restart),
      .tick_o    (tick)
   );

`ifdef UART_RX_PARITY_EN
   logic perr_q;
   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         perr_q <= 1'b0;
      end else if (state_q == StParity && tick && ph_q == PhDec && (maj != ^shift_q)) begin
         perr_q <= 1'b1;
      end else if (err_clr) begin
         perr_q <= 1'b0;
      end
   end
   assign rx_parity_err = perr_q;
`else
   assign rx_parity_err = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         sync_q   <= 2'b11;
         state_q  <= StArm;
         ph_q     <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         s0_q     <= 1'b0;
         s1_q     <= 1'b0;
         commit_q <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], uart_rxd};
         commit_q <= 1'b0;
         // Clears first so that any set below in the same cycle wins.
         if (err_clr) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
         end
         if (rx_ack && valid_q) begin
            valid_q <= 1'b0;
         end
         if (commit_q) begin
            if (!valid_q || rx_ack) begin
               data_q  <= shift_q;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end

         case (state_q)
            StArm: begin
               if (!rxs) begin
                  ph_q <= '0;
               end else if (tick) begin
                  ph_q <= ph_q + 1'b1;
                  if (ph_q == PhLast) begin
                     state_q <= StIdle;
                  end
               end
            end
            StIdle: begin
               if (!rxs) begin
                  ph_q    <= '0;
                  state_q <= StStart;
               end
            end
            default: begin
               if (tick) begin
                  ph_q <= ph_q + 1'b1;
                  if (ph_q == PhS0) s0_q <= rxs;
                  if (ph_q == PhS1) s1_q <= rxs;
                  if (ph_q == PhDec) begin
                     case (state_q)
                        StStart: if (maj) state_q <= StIdle;
                        StData:  shift_q <= {maj, shift_q[7:1]};
                        StStop: begin
                           if (maj) begin
                              commit_q <= 1'b1;
                              state_q  <= StIdle;
                           end else begin
                              ferr_q  <= 1'b1;
                              ph_q    <= '0;
                              state_q <= StArm;
                           end
                        end
                        default: ;
                     endcase
                  end
                  // Bit boundaries advance on phase wrap.
                  if (ph_q == PhLast) begin
                     case (state_q)
                        StStart: begin
                           bit_q   <= '0;
                           state_q <= StData;
                        end
                        StData: begin
                           bit_q <= bit_q + 1'b1;
                           if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                              state_q <= StParity;
`else
                              state_q <= StStop;
`endif
                           end
                        end
                        StParity: state_q <= StStop;
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_overrun   = ovr_q;
   assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend at DIV=4 (64 clocks per bit).
module tb_uart_rx_frontend;

`ifdef UART_RX_PARITY_EN
   localparam bit ParEn = 1'b1;
`else
   localparam bit ParEn = 1'b0;
`endif

   logic       clk_in = 1'b0;
   logic       sys_rstn = 1'b0;
   logic       uart_rxd = 1'b0;
   logic       rx_ack = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, rx_overrun, rx_frame_err, rx_parity_err;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   logic       auto_ack = 1'b1;

   uart_rx_frontend #(
      .CLK_FREQ   (640),
      .BAUD       (10),
      .OVERSAMPLE (16),
      .DIV        (4)
   ) dut (
      .clk_in        (clk_in),
      .sys_rstn      (sys_rstn),
      .uart_rxd      (uart_rxd),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ack        (rx_ack),
      .err_clr       (err_clr),
      .rx_overrun    (rx_overrun),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic v, input int glitch_at);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk_in);
         uart_rxd = (i == glitch_at) ? ~v : v;
      end
   endtask

   // par_mode 0: parity bit only if enabled (correct); 1: always send a 0 parity bit.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit,
                             input bit par_mode);
      send_bit(1'b0, -1);
      for (int i = 0; i < 8; i++) send_bit(d[i], (i == gbit) ? 36 : -1);
      if (par_mode) send_bit(1'b0, -1);
      else if (ParEn) send_bit(^d, -1);
      send_bit(stop, -1);
      @(negedge clk_in);
      uart_rxd = 1'b1;
   endtask

   task automatic idle(input int n);
      uart_rxd = 1'b1;
      repeat (n) @(negedge clk_in);
   endtask

   task automatic pulse_clr();
      @(negedge clk_in);
      err_clr = 1'b1;
      @(negedge clk_in);
      err_clr = 1'b0;
      @(negedge clk_in);
   endtask

   // Monitor: pops the scoreboard on each rising rx_valid and drives rx_ack.
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk_in);
         if (rx_valid && !prev) begin
            if (exp_q.size() == 0) chk("spurious_valid", 32'(rx_valid), 32'd0);
            else chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
         end
         prev   = rx_valid;
         rx_ack = rx_valid && auto_ack && !rx_ack;
      end
   end

   initial begin
      repeat (5) @(negedge clk_in);
      chk("reset_valid", 32'(rx_valid), 32'd0);
      chk("reset_data", 32'(rx_data), 32'h00);
      chk("reset_ovr", 32'(rx_overrun), 32'd0);
      chk("reset_ferr", 32'(rx_frame_err), 32'd0);
      chk("reset_perr", 32'(rx_parity_err), 32'd0);
      sys_rstn = 1'b1;

      // Line held low through and after reset.
      repeat (200) @(negedge clk_in);
      chk("held_low_ferr", 32'(rx_frame_err), 32'd0);
      chk("held_low_valid", 32'(rx_valid), 32'd0);
      idle(100);
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, -1, 1'b0);
      idle(20);

      // Back-to-back frames with acks.
      exp_q.push_back(8'hA3);
      exp_q.push_back(8'h3C);
      send_frame(8'hA3, 1'b1, -1, 1'b0);
      send_frame(8'h3C, 1'b1, -1, 1'b0);
      idle(20);
      chk("b2b_ovr", 32'(rx_overrun), 32'd0);

      // Overrun: 0x22 dropped while 0x11 is held.
      auto_ack = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, -1, 1'b0);
      send_frame(8'h22, 1'b1, -1, 1'b0);
      idle(10);
      chk("ovr_valid", 32'(rx_valid), 32'd1);
      chk("ovr_data", 32'(rx_data), 32'h11);
      chk("ovr_flag", 32'(rx_overrun), 32'd1);
      pulse_clr();
      chk("ovr_cleared", 32'(rx_overrun), 32'd0);
      chk("ovr_still_valid", 32'(rx_valid), 32'd1);
      auto_ack = 1'b1;
      repeat (4) @(negedge clk_in);
      chk("pop_valid", 32'(rx_valid), 32'd0);
      chk("pop_data_held", 32'(rx_data), 32'h11);

      // Bad stop bit, re-arm, then a good frame.
      send_frame(8'h7E, 1'b0, -1, 1'b0);
      idle(64 * 16);
      chk("ferr_flag", 32'(rx_frame_err), 32'd1);
      pulse_clr();
      chk("ferr_cleared", 32'(rx_frame_err), 32'd0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, -1, 1'b0);
      idle(20);

      // Short start glitch, then a 1-clock glitch in data bit 3.
      uart_rxd = 1'b0;
      repeat (20) @(negedge clk_in);
      idle(100);
      chk("glitch_valid", 32'(rx_valid), 32'd0);
      chk("glitch_ferr", 32'(rx_frame_err), 32'd0);
      chk("glitch_ovr", 32'(rx_overrun), 32'd0);
      exp_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1, 3, 1'b0);
      idle(20);

      // 0x07 with a wrong (0) parity bit.
      if (ParEn) exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, -1, 1'b1);
      idle(80);
      chk("par_perr", 32'(rx_parity_err), ParEn ? 32'd1 : 32'd0);
      chk("par_ferr", 32'(rx_frame_err), ParEn ? 32'd0 : 32'd1);

      idle(50);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
